icepic_gpio_in: RTL and testbench
=================================

Name: icepic_gpio_in

Overview:
Input-direction GPIO port for the icepic_12 core, complementing its gpio_out path. It synchronises and debounces external pins and presents a stable value for the CPU to read. It also provides per-bit interrupt-on-change flags, with write-one-to-clear acknowledge and a combined irq line. It sits at board top between the pins and the CPU's GPIO read and interrupt inputs.

Parameters:
WIDTH, 8, number of input pins.
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised level must differ from stable before it is accepted; legal range >= 1.
CNT_W, derived localparam $clog2(DEBOUNCE_CYCLES+1), width of the per-bit debounce counter.

Ports:
clk_in  input  1  system clock.
reset  input  1  reset, synchronous, active-high; clock clk_in.
pin_in  input  WIDTH  asynchronous external pins.
ioc_mask  input  WIDTH  per-bit interrupt-on-change enable; 1 = enabled.
ioc_clr  input  WIDTH  write-one-to-clear strobe for ioc_flag, sampled each cycle.
gpio_rd_data  output  WIDTH  debounced stable pin value, registered.
ioc_flag  output  WIDTH  latched change flags.
irq_out  output  1  OR of ioc_flag, registered.

Behaviour:
- Reset values: gpio_rd_data=0, ioc_flag=0, irq_out=0, sync regs=0, debounce counters=0. State=INIT, init counter=0.
- Synchroniser: two flops per bit, sync1<=pin_in, sync2<=sync1. No logic between the two stages.
- FSM has two states, INIT and RUN.
  - INIT: stable<=sync2 every edge. Counters are held at 0. No flags are set.
  - INIT->RUN on the 3rd rising edge with reset low. Power-up pin levels never raise flags.
- RUN, per bit at each edge:
  - if sync2==stable: cnt<=0.
  - else if cnt==DEBOUNCE_CYCLES-1: stable<=sync2, cnt<=0, change event.
  - else: cnt<=cnt+1.
- Latency: a pin level first present at edge k, and held, appears on gpio_rd_data after edge k+1+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles is discarded. The counter restarts from 0 when sync2 returns to stable.
- Change event on bit i with ioc_mask[i]=1: ioc_flag[i]<=1 on the same edge as the stable update.
  - Both rising and falling edges set the flag.
  - Masked bits still update gpio_rd_data.
- ioc_clr[i]=1 clears ioc_flag[i] on the next edge. A simultaneous set and clear on the same edge leaves the flag at 1 (set wins).
- ioc_mask changes are not retroactive. Clearing a mask bit does not clear an existing flag.
- irq_out<=|next ioc_flag, so it asserts on the same edge as the flag.
- Reset asserted mid-debounce or mid-flag: everything returns to reset values and the block re-enters INIT. No pending counts survive.
- Counter never exceeds DEBOUNCE_CYCLES-1. No wrap is possible.

Optional Feature:
GPIO_DEBOUNCE_EN.
- Defined: debounce counters as above.
- Undefined: counters are not generated and stable<=sync2 every edge in RUN. This is timing-identical to DEBOUNCE_CYCLES=1, with latency edge k+2, and DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package icepic_gpio_pkg: state enum {INIT, RUN}, INIT_CYCLES=3, default WIDTH and DEBOUNCE_CYCLES constants.
- Sub-module icepic_gpio_in_bit: one bit containing the synchroniser, debounce counter, stable register and change-event output.
  - Instantiated WIDTH times via generate.
  - The INIT/RUN FSM and the flag/irq logic stay in the top module.

Test Plan:
- Reset, pin_in=8'hA5 held -> gpio_rd_data=8'hA5 after INIT, ioc_flag=0, irq_out=0.
- RUN, DEBOUNCE_CYCLES=4, mask=8'hFF, bit0 0->1 at edge k -> gpio_rd_data[0]=1 and ioc_flag=8'h01 after edge k+5, irq_out=1 on the same edge.
- 3-cycle pulse on bit3 -> gpio_rd_data, ioc_flag and all counters unchanged. Then a 4-cycle pulse -> bit3 sets, then clears, with flag[3]=1.
- flag[2] set, ioc_clr=8'h04 on the same edge as a new bit2 change event -> flag stays 1. ioc_clr=8'h04 alone next cycle -> flag=0, irq_out=0.
- mask=8'hFE, bit0 toggles -> gpio_rd_data[0] follows, ioc_flag[0] stays 0.
- Reset asserted while bit5 cnt=2 with flags=8'h21 -> all outputs 0. Pins held -> no flags after re-INIT. Build without GPIO_DEBOUNCE_EN -> latency 2 edges.

Source files
------------

// File: rtl/icepic_gpio_pkg.sv
// Shared types and defaults for the icepic_12 GPIO input port.
// Debouncing is built only when GPIO_DEBOUNCE_EN is defined.
package icepic_gpio_pkg;

   typedef enum logic {
      INIT,
      RUN
   } gpio_state_e;

   localparam int INIT_CYCLES         = 3;
   localparam int DEF_WIDTH           = 8;
   localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/icepic_gpio_in_bit.sv
// One GPIO input bit: two-flop synchroniser, optional debounce counter, stable register.
// Build option GPIO_DEBOUNCE_EN selects the debounced variant.
module icepic_gpio_in_bit
   import icepic_gpio_pkg::*;
`ifdef GPIO_DEBOUNCE_EN
   #(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
   )
`endif
   (
   input  logic clk_in,
   input  logic reset,
   input  logic pin,
   input  logic run,
   output logic stable,
   output logic change
   );

   logic sync1;
   logic sync2;
   logic differ;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
      end
   end

   assign differ = (sync2 != stable);

`ifdef GPIO_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   assign change = run && differ && (cnt == CNT_LAST);

   // A new level is accepted only after it has been seen for DEBOUNCE_CYCLES edges in a row
   always_ff @(posedge clk_in) begin
      if (reset) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (!run) begin
         stable <= sync2;
         cnt    <= '0;
      end else if (!differ) begin
         cnt    <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= sync2;
         cnt    <= '0;
      end else begin
         cnt    <= cnt + CNT_W'(1);
      end
   end
`else
   assign change = run && differ;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         stable <= 1'b0;
      end else begin
         stable <= sync2;
      end
   end
`endif

endmodule

// File: rtl/icepic_gpio_in.sv
// GPIO input port for icepic_12: per-bit sync/debounce, interrupt-on-change flags, irq line.
// Define GPIO_DEBOUNCE_EN to enable the debounce counters.
module icepic_gpio_in
   import icepic_gpio_pkg::*;
   #(
   parameter int WIDTH           = DEF_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
   )
   (
   input  logic             clk_in,
   input  logic             reset,
   input  logic [WIDTH-1:0] pin_in,
   input  logic [WIDTH-1:0] ioc_mask,
   input  logic [WIDTH-1:0] ioc_clr,
   output logic [WIDTH-1:0] gpio_rd_data,
   output logic [WIDTH-1:0] ioc_flag,
   output logic             irq_out
   );

   localparam logic [1:0] INIT_LAST = 2'(INIT_CYCLES - 1);

   gpio_state_e      state;
   gpio_state_e      state_next;
   logic [1:0]       init_cnt;
   logic [1:0]       init_cnt_next;
   logic             run;
   logic [WIDTH-1:0] stable_vec;
   logic [WIDTH-1:0] change_vec;
   logic [WIDTH-1:0] flag_next;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state    <= INIT;
         init_cnt <= 2'd0;
      end else begin
         state    <= state_next;
         init_cnt <= init_cnt_next;
      end
   end

   // INIT lets the synchronisers fill so power-up levels never look like changes
   always_comb begin
      state_next    = state;
      init_cnt_next = init_cnt;
      case (state)
         INIT: begin
            if (init_cnt == INIT_LAST) begin
               state_next    = RUN;
               init_cnt_next = 2'd0;
            end else begin
               init_cnt_next = init_cnt + 2'd1;
            end
         end
         RUN: begin
            state_next = RUN;
         end
         default: begin
            state_next    = INIT;
            init_cnt_next = 2'd0;
         end
      endcase
   end

   assign run = (state == RUN);

   if (DEBOUNCE_CYCLES >= 1) begin : g_bits
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         icepic_gpio_in_bit
`ifdef GPIO_DEBOUNCE_EN
            #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
            u_bit (
            .clk_in (clk_in),
            .reset  (reset),
            .pin    (pin_in[i]),
            .run    (run),
            .stable (stable_vec[i]),
            .change (change_vec[i])
            );
      end
   end else begin : g_bad_depth
      assign stable_vec = '0;
      assign change_vec = '0;
   end

   assign gpio_rd_data = stable_vec;

   // Set wins over a same-edge clear; irq follows the next flag value on the same edge
   assign flag_next = (ioc_flag & ~ioc_clr) | (change_vec & ioc_mask);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         ioc_flag <= '0;
         irq_out  <= 1'b0;
      end else begin
         ioc_flag <= flag_next;
         irq_out  <= |flag_next;
      end
   end

endmodule

// File: tb/tb_icepic_gpio_in.sv
// Directed self-checking bench for icepic_gpio_in; expected latency follows GPIO_DEBOUNCE_EN.
module tb_icepic_gpio_in;

`ifdef GPIO_DEBOUNCE_EN
   localparam int DEB = 4;
`else
   localparam int DEB = 1;
`endif

   logic       clk_in = 1'b0;
   logic       reset  = 1'b1;
   logic [7:0] pin_in;
   logic [7:0] ioc_mask;
   logic [7:0] ioc_clr;
   logic [7:0] gpio_rd_data;
   logic [7:0] ioc_flag;
   logic       irq_out;

   int checkCount = 0;
   int errorCount = 0;

   icepic_gpio_in #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
      .clk_in       (clk_in),
      .reset        (reset),
      .pin_in       (pin_in),
      .ioc_mask     (ioc_mask),
      .ioc_clr      (ioc_clr),
      .gpio_rd_data (gpio_rd_data),
      .ioc_flag     (ioc_flag),
      .irq_out      (irq_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic applyStimulus(input logic [7:0] pins, input logic [7:0] mask, input logic [7:0] clr);
      pin_in   = pins;
      ioc_mask = mask;
      ioc_clr  = clr;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [7:0] data, input logic [7:0] flag, input logic irq);
      checkOutput({tag, "_data"}, gpio_rd_data, data);
      checkOutput({tag, "_flag"}, ioc_flag, flag);
      checkOutput({tag, "_irq"}, {7'd0, irq_out}, {7'd0, irq});
   endtask

   initial begin
      applyStimulus(8'hA5, 8'hFF, 8'h00);
      reset = 1'b1;
      step(2);
      checkAll("reset", 8'h00, 8'h00, 1'b0);

      // INIT: stable copies sync2 which only holds A5 after the second edge
      reset = 1'b0;
      step(2);
      checkAll("init_fill", 8'h00, 8'h00, 1'b0);
      step(1);
      checkAll("init_done", 8'hA5, 8'h00, 1'b0);
      step(4);
      checkAll("powerup_noflag", 8'hA5, 8'h00, 1'b0);

      // Bit0 falls; accepted on edge k+1+DEB
      applyStimulus(8'hA4, 8'hFF, 8'h00);
      step(DEB + 1);
      checkAll("b0_before", 8'hA5, 8'h00, 1'b0);
      step(1);
      checkAll("b0_after", 8'hA4, 8'h01, 1'b1);

      applyStimulus(8'hA4, 8'hFF, 8'h01);
      step(1);
      checkAll("b0_clr", 8'hA4, 8'h00, 1'b0);
      applyStimulus(8'hA4, 8'hFF, 8'h00);

`ifdef GPIO_DEBOUNCE_EN
      // Pulse one cycle too short is discarded
      applyStimulus(8'hAC, 8'hFF, 8'h00);
      step(DEB - 1);
      applyStimulus(8'hA4, 8'hFF, 8'h00);
      step(DEB + 3);
      checkAll("glitch", 8'hA4, 8'h00, 1'b0);
`endif

      // Pulse exactly DEB cycles long passes through and returns
      applyStimulus(8'hAC, 8'hFF, 8'h00);
      step(DEB);
      applyStimulus(8'hA4, 8'hFF, 8'h00);
      step(2);
      checkAll("pulse_hi", 8'hAC, 8'h08, 1'b1);
      step(DEB);
      checkAll("pulse_lo", 8'hA4, 8'h08, 1'b1);
      applyStimulus(8'hA4, 8'hFF, 8'hFF);
      step(1);
      checkAll("pulse_clr", 8'hA4, 8'h00, 1'b0);

      // Set and clear on the same edge: set wins
      applyStimulus(8'hA0, 8'hFF, 8'h00);
      step(DEB + 2);
      checkAll("b2_set", 8'hA0, 8'h04, 1'b1);
      applyStimulus(8'hA4, 8'hFF, 8'h00);
      step(DEB + 1);
      checkOutput("b2_pending_data", gpio_rd_data, 8'hA0);
      applyStimulus(8'hA4, 8'hFF, 8'h04);
      step(1);
      checkAll("b2_setwins", 8'hA4, 8'h04, 1'b1);
      step(1);
      checkAll("b2_cleared", 8'hA4, 8'h00, 1'b0);

      // Masked bit still updates read data but never flags
      applyStimulus(8'hA5, 8'hFE, 8'h00);
      step(DEB + 2);
      checkAll("mask_rise", 8'hA5, 8'h00, 1'b0);
      applyStimulus(8'hA4, 8'hFE, 8'h00);
      step(DEB + 2);
      checkAll("mask_fall", 8'hA4, 8'h00, 1'b0);

      // Reset in the middle of a bit5 debounce with flags 21
      applyStimulus(8'h85, 8'hFF, 8'h00);
      step(DEB + 2);
      checkAll("pre_reset", 8'h85, 8'h21, 1'b1);
      applyStimulus(8'hA5, 8'hFF, 8'h00);
      step(DEB);
      checkAll("mid_debounce", 8'h85, 8'h21, 1'b1);
      reset = 1'b1;
      step(1);
      checkAll("mid_reset", 8'h00, 8'h00, 1'b0);
      reset = 1'b0;
      step(3);
      checkAll("reinit", 8'hA5, 8'h00, 1'b0);
      step(8);
      checkAll("reinit_quiet", 8'hA5, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
